// File: rtl/pong_match_controller.sv
// Pong match sequencer: game state, scores, winner colour, serve requests and run gating.
// Optional key0 debouncer is compiled in with `define PONG_PAUSE_DEBOUNCE_EN.
module pong_match_controller #(
    parameter int          WIN_SCORE         = 7,
    parameter int          SERVE_DELAY_TICKS = 60,
    parameter int          DEBOUNCE_CYCLES   = 250000,
    parameter logic [2:0]  PLAYER_1_COLOR    = 3'b100,
    parameter logic [2:0]  PLAYER_2_COLOR    = 3'b001
) (
    input  logic       CLOCK_25,
    input  logic       reset,
    input  logic       tick,
    input  logic       key0,
    input  logic       miss_1,
    input  logic       miss_2,
    output logic       run,
    output logic       serve_req,
    output logic       serve_side,
    output logic [2:0] score_1,
    output logic [2:0] score_2,
    output logic [2:0] winner_color,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    logic       r_sync_1;
    logic       r_sync_2;
    logic       r_level_prev;
    logic       w_level;
    logic       w_press;

    state_t     r_state;
    state_t     r_resume;
    logic [7:0] r_tick_cnt;
    logic [2:0] r_score_1;
    logic [2:0] r_score_2;
    logic [2:0] r_winner;
    logic       r_serve_side;
    logic       r_serve_req;
    logic       r_run;
    logic [2:0] w_score_1_inc;
    logic [2:0] w_score_2_inc;

    // Two-flop synchronizer for the asynchronous button; released level is 1
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= key0;
            r_sync_2 <= r_sync_1;
        end
    end

`ifdef PONG_PAUSE_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b1;
        end else if (r_sync_2 != r_db_level) begin
            if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db_level <= r_sync_2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_level = r_db_level;
`else
    // The debounce threshold has no effect here; both arms select the synchronized level
    if (DEBOUNCE_CYCLES >= 0) begin : g_direct_level
        assign w_level = r_sync_2;
    end else begin : g_direct_level_alt
        assign w_level = r_sync_2;
    end
`endif

    // Edge detector state for the conditioned level; reset discards any pending press
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_level_prev <= 1'b1;
        end else begin
            r_level_prev <= w_level;
        end
    end

    assign w_press       = r_level_prev & ~w_level;
    assign w_score_1_inc = r_score_1 + 3'd1;
    assign w_score_2_inc = r_score_2 + 3'd1;

    // Match state machine with registered outputs; miss_1 outranks miss_2, misses outrank press
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_resume     <= ST_SERVE;
            r_tick_cnt   <= 8'd0;
            r_score_1    <= 3'd0;
            r_score_2    <= 3'd0;
            r_winner     <= 3'd0;
            r_serve_side <= 1'b0;
            r_serve_req  <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_serve_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_score_1    <= 3'd0;
                        r_score_2    <= 3'd0;
                        r_serve_side <= 1'b0;
                        r_tick_cnt   <= 8'd0;
                        r_serve_req  <= 1'b1;
                        r_state      <= ST_SERVE;
                    end else begin
                        r_run <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (w_press) begin
                        r_resume <= ST_SERVE;
                        r_state  <= ST_PAUSED;
                    end else if (tick) begin
                        if (r_tick_cnt == 8'(SERVE_DELAY_TICKS - 1)) begin
                            r_state <= ST_PLAY;
                            r_run   <= 1'b1;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 8'd1;
                        end
                    end else begin
                        r_run <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (miss_1) begin
                        r_score_2    <= w_score_2_inc;
                        r_serve_side <= 1'b0;
                        r_run        <= 1'b0;
                        if (w_score_2_inc == 3'(WIN_SCORE)) begin
                            r_winner <= PLAYER_2_COLOR;
                            r_state  <= ST_GAMEOVER;
                        end else begin
                            r_tick_cnt  <= 8'd0;
                            r_serve_req <= 1'b1;
                            r_state     <= ST_SERVE;
                        end
                    end else if (miss_2) begin
                        r_score_1    <= w_score_1_inc;
                        r_serve_side <= 1'b1;
                        r_run        <= 1'b0;
                        if (w_score_1_inc == 3'(WIN_SCORE)) begin
                            r_winner <= PLAYER_1_COLOR;
                            r_state  <= ST_GAMEOVER;
                        end else begin
                            r_tick_cnt  <= 8'd0;
                            r_serve_req <= 1'b1;
                            r_state     <= ST_SERVE;
                        end
                    end else if (w_press) begin
                        r_resume <= ST_PLAY;
                        r_run    <= 1'b0;
                        r_state  <= ST_PAUSED;
                    end else begin
                        r_run <= 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (w_press) begin
                        r_state <= r_resume;
                        r_run   <= (r_resume == ST_PLAY);
                    end else begin
                        r_run <= 1'b0;
                    end
                end
                ST_GAMEOVER: begin
                    if (w_press) begin
                        r_score_1 <= 3'd0;
                        r_score_2 <= 3'd0;
                        r_winner  <= 3'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_run <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_winner <= 3'd0;
                    r_run    <= 1'b0;
                end
            endcase
        end
    end

    assign run          = r_run;
    assign serve_req    = r_serve_req;
    assign serve_side   = r_serve_side;
    assign score_1      = r_score_1;
    assign score_2      = r_score_2;
    assign winner_color = r_winner;
    assign state        = r_state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench for pong_match_controller: directed match scenarios plus random stimulus
// compared every cycle against a rule-level model of the match.
module tb_pong_match_controller;

    localparam int         WS   = 3;
    localparam int         SD   = 4;
    localparam int         DB   = 8;
    localparam logic [2:0] P1C  = 3'b100;
    localparam logic [2:0] P2C  = 3'b001;
`ifdef PONG_PAUSE_DEBOUNCE_EN
    localparam int         LAT  = 3 + DB;
`else
    localparam int         LAT  = 3;
`endif
    localparam int         HOLD = LAT + 1;

    logic       CLOCK_25 = 1'b0;
    logic       reset    = 1'b1;
    logic       tick     = 1'b0;
    logic       key0     = 1'b1;
    logic       miss_1   = 1'b0;
    logic       miss_2   = 1'b0;
    logic       run, serve_req, serve_side;
    logic [2:0] score_1, score_2, winner_color, state;

    int n_tests  = 0;
    int n_fail   = 0;
    int req_seen = 0;

    pong_match_controller #(
        .WIN_SCORE(WS), .SERVE_DELAY_TICKS(SD), .DEBOUNCE_CYCLES(DB),
        .PLAYER_1_COLOR(P1C), .PLAYER_2_COLOR(P2C)
    ) dut (
        .CLOCK_25(CLOCK_25), .reset(reset), .tick(tick), .key0(key0),
        .miss_1(miss_1), .miss_2(miss_2), .run(run), .serve_req(serve_req),
        .serve_side(serve_side), .score_1(score_1), .score_2(score_2),
        .winner_color(winner_color), .state(state)
    );

    initial forever #20 CLOCK_25 = ~CLOCK_25;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rule-level model: game facts, updated once per rising edge from the sampled inputs
    bit       m_valid = 0;
    int       m_state, m_resume, m_cnt, m_s1, m_s2;
    bit       m_side, m_req;
    bit [2:0] m_win;
    bit       hist [0:31];
    bit       m_lvl, m_pend;

    always @(posedge CLOCK_25) begin
        bit press, all_diff;
        for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = key0;
        if (reset) begin
            for (int i = 0; i < 32; i++) hist[i] = 1'b1;
            m_lvl = 1; m_pend = 0;
            m_state = 0; m_resume = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0;
            m_side = 0; m_req = 0; m_win = 3'b000; m_valid = 1;
        end else begin
`ifdef PONG_PAUSE_DEBOUNCE_EN
            press = m_pend;
            all_diff = 1;
            for (int j = 2; j <= DB + 1; j++) if (hist[j] == m_lvl) all_diff = 0;
            if (all_diff) begin
                m_lvl  = ~m_lvl;
                m_pend = (m_lvl == 1'b0);
            end else begin
                m_pend = 0;
            end
`else
            all_diff = 0;
            press = hist[3] & ~hist[2];
`endif
            m_req = 0;
            case (m_state)
                0: if (press) begin
                       m_s1 = 0; m_s2 = 0; m_side = 0; m_cnt = 0; m_req = 1; m_state = 1;
                   end
                1: if (press) begin
                       m_resume = 1; m_state = 3;
                   end else if (tick) begin
                       if (m_cnt == SD - 1) m_state = 2;
                       else m_cnt++;
                   end
                2: if (miss_1 || miss_2) begin
                       if (miss_1) begin m_s2++; m_side = 0; end
                       else        begin m_s1++; m_side = 1; end
                       if (m_s1 == WS || m_s2 == WS) begin
                           m_state = 4;
                           m_win = (m_s2 == WS) ? P2C : P1C;
                       end else begin
                           m_state = 1; m_cnt = 0; m_req = 1;
                       end
                   end else if (press) begin
                       m_resume = 2; m_state = 3;
                   end
                3: if (press) m_state = m_resume;
                4: if (press) begin
                       m_s1 = 0; m_s2 = 0; m_win = 3'b000; m_state = 0;
                   end
                default: m_state = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model, plus serve_req pulse count
    always @(negedge CLOCK_25) begin
        if (m_valid) begin
            check("state",      32'(state),        32'(m_state));
            check("run",        32'(run),          32'(m_state == 2));
            check("serve_req",  32'(serve_req),    32'(m_req));
            check("serve_side", 32'(serve_side),   32'(m_side));
            check("score_1",    32'(score_1),      32'(m_s1));
            check("score_2",    32'(score_2),      32'(m_s2));
            check("winner",     32'(winner_color), 32'((m_state == 4) ? m_win : 3'b000));
            if (serve_req === 1'b1) req_seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_25);
    endtask

    task automatic press_key();
        key0 = 1'b0; cyc(HOLD);
        key0 = 1'b1; cyc(HOLD);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    task automatic miss(input bit a, input bit b);
        miss_1 = a; miss_2 = b; cyc(1);
        miss_1 = 1'b0; miss_2 = 1'b0;
    endtask

    initial begin
        int req0, key_hold;
        cyc(3);
        reset = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_scores", 32'({score_1, score_2, winner_color}), 32'd0);
        check("rst_outs", 32'({run, serve_req, serve_side}), 32'd0);

        // Start and serve
        press_key();
        check("start_state", 32'(state), 32'd1);
        check("start_req_cnt", 32'(req_seen), 32'd1);
        check("start_side", 32'(serve_side), 32'd0);
        ticks(4);
        check("play_state", 32'(state), 32'd2);
        check("play_run", 32'(run), 32'd1);

        // Scoring by player 1
        miss(1'b0, 1'b1);
        check("p1_score", 32'(score_1), 32'd1);
        check("p1_side", 32'(serve_side), 32'd1);
        check("p1_state_run", 32'({state, run}), 32'({3'd1, 1'b0}));
        check("p1_req", 32'(serve_req), 32'd1);
        ticks(4);

        // Player 2 wins 3-1
        for (int g = 0; g < 3; g++) begin
            miss(1'b1, 1'b0);
            if (g < 2) ticks(4);
        end
        check("win_score_2", 32'(score_2), 32'd3);
        check("win_state", 32'(state), 32'd4);
        check("win_color", 32'(winner_color), 32'(P2C));
        press_key();
        check("idle_state", 32'(state), 32'd0);
        check("idle_clear", 32'({score_1, score_2, winner_color}), 32'd0);
        press_key();
        ticks(4);

        // Pause in the middle of a serve
        miss(1'b0, 1'b1);
        req0 = req_seen;
        ticks(2);
        press_key();
        check("pause_state", 32'(state), 32'd3);
        ticks(5);
        check("pause_hold", 32'(state), 32'd3);
        press_key();
        check("resume_state", 32'(state), 32'd1);
        check("resume_no_req", 32'(req_seen), 32'(req0 + 1));
        ticks(2);
        check("resume_play", 32'(state), 32'd2);

        // Both misses and a press landing on the same edge
        key0 = 1'b0;
        cyc(LAT - 1);
        miss(1'b1, 1'b1);
        check("simul_scores", 32'({score_1, score_2}), 32'({3'd1, 3'd1}));
        check("simul_state", 32'(state), 32'd1);
        cyc(HOLD);
        key0 = 1'b1;
        cyc(HOLD);
        check("simul_press_dropped", 32'(state), 32'd1);
        ticks(4);

`ifdef PONG_PAUSE_DEBOUNCE_EN
        // Short glitch rejected, long pulse gives one transition
        key0 = 1'b0; cyc(5);
        key0 = 1'b1; cyc(20);
        check("glitch_ignored", 32'(state), 32'd2);
        key0 = 1'b0; cyc(12);
        key0 = 1'b1; cyc(20);
        check("long_pulse", 32'(state), 32'd3);
        press_key();
        check("long_resume", 32'(state), 32'd2);
`endif

        // Random stimulus against the model
        reset = 1'b1; cyc(2); reset = 1'b0;
        key_hold = 0;
        for (int c = 0; c < 6000; c++) begin
            reset  = ($urandom_range(0, 799) == 0);
            tick   = ($urandom_range(0, 2) == 0);
            miss_1 = ($urandom_range(0, 11) == 0);
            miss_2 = ($urandom_range(0, 11) == 0);
            if (key_hold == 0) begin
                key0     = ~key0;
                key_hold = $urandom_range(1, 2 * HOLD);
            end else begin
                key_hold--;
            end
            cyc(1);
        end
        reset = 1'b0; tick = 1'b0; miss_1 = 1'b0; miss_2 = 1'b0; key0 = 1'b1;
        cyc(2 * HOLD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_match_controller.md
# pong_match_controller

Match sequencer for the Pong game. Owns the game state (idle, serve, play, paused, game over), the two player scores and the winner colour. Gates ball and paddle motion through `run`, and requests ball re-serves from the ball datapath. Sits between the key inputs and the ball/paddle/score logic, all on the 25 MHz pixel clock.

## Interface
- `WIN_SCORE`, default 7: points needed to win; legal range 1..7.
- `SERVE_DELAY_TICKS`, default 60: number of `tick` pulses spent in SERVE before play starts; legal range 1..255.
- `DEBOUNCE_CYCLES`, default 250000: stable-level cycles required on `key0` (used only with debounce compiled in).
- `CLOCK_25`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle game-update strobe (ball clock rate), synchronous to `CLOCK_25`.
- `key0`  in  1  raw pause/start button, active-low, asynchronous.
- `miss_1`  in  1  one-cycle pulse: player 1 missed the ball, so player 2 scores.
- `miss_2`  in  1  one-cycle pulse: player 2 missed the ball, so player 1 scores.
- `run`  out  1  high only in PLAY; enables ball and paddle updates.
- `serve_req`  out  1  one-cycle pulse: the ball datapath reloads the ball at the serve position.
- `serve_side`  out  1  0 = serve from player 1's paddle, 1 = from player 2's paddle.
- `score_1`, `score_2`  out  3  current scores.
- `winner_color`  out  3  `PLAYER_1_COLOR` or `PLAYER_2_COLOR` in GAMEOVER, otherwise 3'b000.
- `state`  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSED=3, GAMEOVER=4.

## Operation
**Button conditioning**
- `key0` passes through a 2-flop synchronizer, then the optional debouncer.
- `press` is a one-cycle pulse on the falling edge of the conditioned level.

**State machine**
- IDLE:
  - `press`: clear both scores, set `serve_side`=0, go to SERVE.
- SERVE:
  - Entry: `serve_req` pulses and the tick counter loads 0.
  - Each `tick`: the counter increments. When `tick` arrives with counter = `SERVE_DELAY_TICKS`-1, go to PLAY.
  - `press`: go to PAUSED with resume=SERVE; the counter is frozen, not reloaded.
- PLAY:
  - `miss_1`: player 2 scores, `serve_side`=0.
  - `miss_2`: player 1 scores, `serve_side`=1.
  - On a score: if the new score equals `WIN_SCORE`, go to GAMEOVER. Otherwise go to SERVE.
  - `press` with no miss: go to PAUSED with resume=PLAY.
- PAUSED:
  - `press`: return to the resume state. No `serve_req` is issued and the counter continues from its frozen value.
  - Misses and ticks are ignored.
- GAMEOVER:
  - Scores hold their final values; `winner_color` shows the scoring player's colour.
  - `press`: clear scores and `winner_color`, go to IDLE.

**Arithmetic**
- Scores are 3-bit and increment by 1. No wrap is possible because the game ends at `WIN_SCORE` ≤ 7.

**Boundary conditions**
- `miss_1` and `miss_2` in the same cycle: `miss_1` has priority; only player 2 scores.
- A miss and `press` in the same cycle in PLAY: the miss wins and `press` is dropped.
- Misses outside PLAY are ignored.
- `tick` is ignored outside SERVE.
- `reset` mid-operation: all registers return to reset values on the next edge; a pending `press` is discarded.

## Timing
- Reset values:
  - `state`=IDLE
  - `run`=0, `serve_req`=0, `serve_side`=0
  - `score_1`=`score_2`=0
  - `winner_color`=000
  - synchronizer/debouncer level = 1 (released)
- All outputs are registered.
- A miss sampled at edge N: scores, `state`, and `run`=0 are visible after edge N. `serve_req` is high for exactly the cycle after edge N when the next state is SERVE.
- `press` latency from a `key0` falling edge:
  - 3 cycles without debounce.
  - 3 + `DEBOUNCE_CYCLES` cycles with debounce.
- SERVE→PLAY: `run` rises in the cycle after the edge that samples the final `tick`.

## Configuration
- `PONG_PAUSE_DEBOUNCE_EN` defined: a counter requires the synchronized `key0` to differ from the current level for `DEBOUNCE_CYCLES` consecutive cycles before the level is accepted. Glitches shorter than that produce no `press`.
- Undefined: the synchronized `key0` is used directly and every falling edge is a `press`. The `DEBOUNCE_CYCLES` parameter is unused.

## Test plan
Bench parameters: WIN_SCORE=3, SERVE_DELAY_TICKS=4, DEBOUNCE_CYCLES=8.
- Start and serve: reset, then one `key0` press → state=1, exactly one `serve_req` pulse, `serve_side`=0; after 4 ticks → state=2 and `run`=1.
- Scoring: in PLAY, `miss_2` pulse → `score_1`=1, `serve_side`=1, state=1, `run`=0 on the next cycle, one `serve_req`.
- Win: three `miss_1` pulses, each followed by a full serve → `score_2`=3, state=4, `winner_color`=`PLAYER_2_COLOR`; a press then gives state=0, scores 0, `winner_color`=000.
- Pause mid-serve: press after 2 ticks, send 5 ticks, press again → state=1 with no extra `serve_req`; 2 more ticks → state=2.
- Simultaneous events: `miss_1`, `miss_2` and a press in the same cycle in PLAY → only `score_2` increments and state=1, not 3.
- Debounce (macro defined): a 5-cycle low glitch on `key0` causes no state change; a 12-cycle low pulse gives exactly one transition.
